// File: rtl/ccip_if_pkg.sv
// Minimal CCI-P transmit/receive channel types shared by the shim and its neighbours.
package ccip_if_pkg;

   typedef logic [511:0] t_ccip_clData;
   typedef logic [63:0]  t_ccip_mmioData;

   typedef struct packed {
      logic [3:0]  vc_sel;
      logic [1:0]  cl_len;
      logic [3:0]  req_type;
      logic [41:0] address;
      logic [15:0] mdata;
   } t_ccip_c0_ReqMemHdr;

   typedef struct packed {
      logic [3:0]  vc_sel;
      logic        sop;
      logic [1:0]  cl_len;
      logic [3:0]  req_type;
      logic [41:0] address;
      logic [15:0] mdata;
   } t_ccip_c1_ReqMemHdr;

   typedef struct packed {
      logic [8:0] tid;
   } t_ccip_c2_RspMmioHdr;

   typedef struct packed {
      t_ccip_c0_ReqMemHdr hdr;
      logic               valid;
   } t_if_ccip_c0_Tx;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      t_ccip_clData       data;
      logic               valid;
   } t_if_ccip_c1_Tx;

   typedef struct packed {
      t_ccip_c2_RspMmioHdr hdr;
      logic                mmioRdValid;
      t_ccip_mmioData      data;
   } t_if_ccip_c2_Tx;

   typedef struct packed {
      t_if_ccip_c0_Tx c0;
      t_if_ccip_c1_Tx c1;
      t_if_ccip_c2_Tx c2;
   } t_if_ccip_Tx;

   typedef struct packed {
      logic [1:0]  vc_used;
      logic        hit_miss;
      logic [1:0]  cl_num;
      logic [3:0]  resp_type;
      logic [15:0] mdata;
   } t_ccip_RspMemHdr;

   typedef struct packed {
      t_ccip_RspMemHdr hdr;
      t_ccip_clData    data;
      logic            rspValid;
      logic            mmioRdValid;
      logic            mmioWrValid;
   } t_if_ccip_c0_Rx;

   typedef struct packed {
      t_ccip_RspMemHdr hdr;
      logic            rspValid;
   } t_if_ccip_c1_Rx;

   typedef struct packed {
      logic           c0TxAlmFull;
      logic           c1TxAlmFull;
      t_if_ccip_c0_Rx c0;
      t_if_ccip_c1_Rx c1;
   } t_if_ccip_Rx;

endpackage

// File: rtl/ccip_tx_shim_pkg.sv
// Shared constants and entry types for the CCI-P transmit shim.
package ccip_tx_shim_pkg;
   import ccip_if_pkg::*;

   localparam int CCIP_TX_SHIM_DEPTH         = 16;
   localparam int CCIP_TX_SHIM_ALMFULL_SLACK = 8;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      t_ccip_clData       data;
   } t_c1_entry;

   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ccip_tx_chan_fifo.sv
// Per-channel request FIFO; a push into a full FIFO is taken only if a pop frees a slot that cycle.
module ccip_tx_chan_fifo #(
   parameter type T     = logic,
   parameter int  DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  T                       push_entry,
   input  logic                   pop,
   output logic [$clog2(DEPTH):0] count,
   output logic [$clog2(DEPTH):0] count_nxt,
   output T                       head
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   always_comb begin
      pop_ok   = pop && (count_q != '0);
      push_ok  = push && ((count_q != FULL) || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_entry;
   end

   assign count     = count_q;
   assign count_nxt = count_d;
   assign head      = mem_q[rd_ptr_q];

endmodule

// File: rtl/ccip_tx_shim.sv
// Buffers one sub-AFU's c0/c1 requests toward the vai_mux slot and relays flow control back.
// Define CCIP_TX_SHIM_STATS_EN to build the overflow flags and occupancy high-water marks.
module ccip_tx_shim
   import ccip_if_pkg::*;
   import ccip_tx_shim_pkg::*;
#(
   parameter int DEPTH         = CCIP_TX_SHIM_DEPTH,
   parameter int ALMFULL_SLACK = CCIP_TX_SHIM_ALMFULL_SLACK
) (
   input  logic                   pClk,
   input  logic                   pck_cp2af_softReset,
   input  t_if_ccip_Tx            afu_sTx,
   output t_if_ccip_Rx            afu_sRx,
   output t_if_ccip_Tx            up_sTx,
   input  t_if_ccip_Rx            up_sRx,
   output logic [1:0]             ovf_err,
   output logic [$clog2(DEPTH):0] hwm_c0,
   output logic [$clog2(DEPTH):0] hwm_c1
);
   localparam int CW = cnt_width(DEPTH);
   localparam logic [CW-1:0] AF_THRESH = CW'(DEPTH - ALMFULL_SLACK);

   logic               rst;
   logic               pop_c0, pop_c1;
   logic [CW-1:0]      cnt_c0, cnt_c1, cnt_nxt_c0, cnt_nxt_c1;
   t_ccip_c0_ReqMemHdr head_c0;
   t_c1_entry          head_c1, push_c1_entry;
   t_if_ccip_Tx        up_tx_q, up_tx_d;
   t_if_ccip_Rx        afu_rx_q, afu_rx_d;

   assign rst           = pck_cp2af_softReset;
   assign push_c1_entry = '{hdr: afu_sTx.c1.hdr, data: afu_sTx.c1.data};
   assign pop_c0        = (cnt_c0 != '0) && !up_sRx.c0TxAlmFull;
   assign pop_c1        = (cnt_c1 != '0) && !up_sRx.c1TxAlmFull;

   ccip_tx_chan_fifo #(.T(t_ccip_c0_ReqMemHdr), .DEPTH(DEPTH)) u_fifo_c0 (
      .clk        (pClk),
      .rst        (rst),
      .push       (afu_sTx.c0.valid),
      .push_entry (afu_sTx.c0.hdr),
      .pop        (pop_c0),
      .count      (cnt_c0),
      .count_nxt  (cnt_nxt_c0),
      .head       (head_c0)
   );

   ccip_tx_chan_fifo #(.T(t_c1_entry), .DEPTH(DEPTH)) u_fifo_c1 (
      .clk        (pClk),
      .rst        (rst),
      .push       (afu_sTx.c1.valid),
      .push_entry (push_c1_entry),
      .pop        (pop_c1),
      .count      (cnt_c1),
      .count_nxt  (cnt_nxt_c1),
      .head       (head_c1)
   );

   always_comb begin
      up_tx_d          = '0;
      up_tx_d.c0.valid = pop_c0;
      up_tx_d.c0.hdr   = pop_c0 ? head_c0 : '0;
      up_tx_d.c1.valid = pop_c1;
      up_tx_d.c1.hdr   = pop_c1 ? head_c1.hdr : '0;
      up_tx_d.c1.data  = pop_c1 ? head_c1.data : '0;
      up_tx_d.c2       = afu_sTx.c2;

      afu_rx_d             = up_sRx;
      afu_rx_d.c0TxAlmFull = (cnt_nxt_c0 >= AF_THRESH);
      afu_rx_d.c1TxAlmFull = (cnt_nxt_c1 >= AF_THRESH);
   end

   // Almost-full resets high so the AFU holds off until the FIFOs are known empty.
   always_ff @(posedge pClk or posedge rst) begin
      if (rst) begin
         up_tx_q              <= '0;
         afu_rx_q             <= '0;
         afu_rx_q.c0TxAlmFull <= 1'b1;
         afu_rx_q.c1TxAlmFull <= 1'b1;
      end else begin
         up_tx_q  <= up_tx_d;
         afu_rx_q <= afu_rx_d;
      end
   end

   assign up_sTx  = up_tx_q;
   assign afu_sRx = afu_rx_q;

`ifdef CCIP_TX_SHIM_STATS_EN
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [1:0]    ovf_q, ovf_d;
   logic [CW-1:0] hwm_c0_q, hwm_c0_d, hwm_c1_q, hwm_c1_d;

   always_comb begin
      ovf_d = ovf_q;
      if (afu_sTx.c0.valid && (cnt_c0 == FULL) && !pop_c0) ovf_d[0] = 1'b1;
      if (afu_sTx.c1.valid && (cnt_c1 == FULL) && !pop_c1) ovf_d[1] = 1'b1;
      hwm_c0_d = (cnt_c0 > hwm_c0_q) ? cnt_c0 : hwm_c0_q;
      hwm_c1_d = (cnt_c1 > hwm_c1_q) ? cnt_c1 : hwm_c1_q;
   end

   always_ff @(posedge pClk or posedge rst) begin
      if (rst) begin
         ovf_q    <= '0;
         hwm_c0_q <= '0;
         hwm_c1_q <= '0;
      end else begin
         ovf_q    <= ovf_d;
         hwm_c0_q <= hwm_c0_d;
         hwm_c1_q <= hwm_c1_d;
      end
   end

   assign ovf_err = ovf_q;
   assign hwm_c0  = hwm_c0_q;
   assign hwm_c1  = hwm_c1_q;
`else
   assign ovf_err = '0;
   assign hwm_c0  = '0;
   assign hwm_c1  = '0;
`endif

endmodule

// File: tb/tb_ccip_tx_shim.sv
// Directed bench for ccip_tx_shim at DEPTH=16, ALMFULL_SLACK=8.
module tb_ccip_tx_shim;
   import ccip_if_pkg::*;

`ifdef CCIP_TX_SHIM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic               pClk = 1'b0;
   logic               rst;
   t_if_ccip_Tx        afu_tx, up_tx;
   t_if_ccip_Rx        afu_rx, up_rx;
   logic [1:0]         ovf;
   logic [4:0]         hwm0, hwm1;
   int                 checks = 0;
   int                 failures = 0;
   int                 stale = 0;
   t_ccip_c0_ReqMemHdr h0;

   ccip_tx_shim dut (
      .pClk                (pClk),
      .pck_cp2af_softReset (rst),
      .afu_sTx             (afu_tx),
      .afu_sRx             (afu_rx),
      .up_sTx              (up_tx),
      .up_sRx              (up_rx),
      .ovf_err             (ovf),
      .hwm_c0              (hwm0),
      .hwm_c1              (hwm1)
   );

   always #5 pClk = ~pClk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pClk);
      #1;
   endtask

   initial begin
      rst    = 1'b1;
      afu_tx = '0;
      up_rx  = '0;
      repeat (3) tick();

      // reset state
      chk("rst_c0_almfull", afu_rx.c0TxAlmFull, 1);
      chk("rst_c1_almfull", afu_rx.c1TxAlmFull, 1);
      chk("rst_up_c0_valid", up_tx.c0.valid, 0);
      chk("rst_up_c1_valid", up_tx.c1.valid, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_hwm0", hwm0, 0);

      rst = 1'b0;
      tick();
      chk("rel_c0_almfull", afu_rx.c0TxAlmFull, 0);
      chk("rel_c1_almfull", afu_rx.c1TxAlmFull, 0);

      // single c0 request latency
      h0 = '{vc_sel: 4'h1, cl_len: 2'b00, req_type: 4'h0,
             address: 42'h12_3456_789A, mdata: 16'h0A5A};
      afu_tx.c0.hdr   = h0;
      afu_tx.c0.valid = 1'b1;
      tick();
      afu_tx.c0.valid = 1'b0;
      chk("lat_not_yet", up_tx.c0.valid, 0);
      tick();
      chk("lat_valid", up_tx.c0.valid, 1);
      chk("lat_hdr", up_tx.c0.hdr, h0);
      tick();
      chk("lat_one_cycle", up_tx.c0.valid, 0);

      // c1 backpressure then in-order drain
      up_rx.c1TxAlmFull = 1'b1;
      for (int i = 0; i < 8; i++) begin
         afu_tx.c1.valid     = 1'b1;
         afu_tx.c1.hdr.mdata = 16'h0100 + 16'(i);
         afu_tx.c1.data      = {8{64'h1111_0000_0000_0000 + 64'(i)}};
         tick();
         chk("bp_c1_invalid", up_tx.c1.valid, 0);
         chk("bp_c1_almfull", afu_rx.c1TxAlmFull, (i == 7) ? 1 : 0);
      end
      afu_tx.c1.valid   = 1'b0;
      up_rx.c1TxAlmFull = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("drain_c1_valid", up_tx.c1.valid, 1);
         chk("drain_c1_mdata", up_tx.c1.hdr.mdata, 16'h0100 + 16'(i));
         chk("drain_c1_data", up_tx.c1.data[63:0], 64'h1111_0000_0000_0000 + 64'(i));
         if (i == 0) chk("drain_c1_almfull_off", afu_rx.c1TxAlmFull, 0);
      end
      tick();
      chk("drain_c1_done", up_tx.c1.valid, 0);
      chk("hwm1_after_bp", hwm1, STATS ? 8 : 0);

      // c0 overflow with upstream blocked
      up_rx.c0TxAlmFull = 1'b1;
      for (int i = 0; i < 17; i++) begin
         afu_tx.c0.valid     = 1'b1;
         afu_tx.c0.hdr       = '0;
         afu_tx.c0.hdr.mdata = 16'h0200 + 16'(i);
         tick();
      end
      afu_tx.c0.valid = 1'b0;
      tick();
      chk("ovf_flag", ovf, STATS ? 2'b01 : 2'b00);
      chk("ovf_hwm0", hwm0, STATS ? 16 : 0);
      chk("ovf_c0_invalid", up_tx.c0.valid, 0);
      chk("ovf_c0_almfull", afu_rx.c0TxAlmFull, 1);

      // full boundary: push and pop in the same cycle at count 16
      up_rx.c0TxAlmFull   = 1'b0;
      afu_tx.c0.valid     = 1'b1;
      afu_tx.c0.hdr.mdata = 16'h02FF;
      tick();
      afu_tx.c0.valid = 1'b0;
      chk("full_pop_valid", up_tx.c0.valid, 1);
      chk("full_pop_mdata", up_tx.c0.hdr.mdata, 16'h0200);
      chk("full_ovf_same", ovf, STATS ? 2'b01 : 2'b00);
      chk("full_almfull", afu_rx.c0TxAlmFull, 1);
      for (int i = 1; i < 16; i++) begin
         tick();
         chk("full_drain_mdata", up_tx.c0.hdr.mdata, 16'h0200 + 16'(i));
         chk("full_drain_valid", up_tx.c0.valid, 1);
      end
      tick();
      chk("full_last_mdata", up_tx.c0.hdr.mdata, 16'h02FF);
      chk("full_last_valid", up_tx.c0.valid, 1);
      tick();
      chk("full_drain_done", up_tx.c0.valid, 0);
      chk("full_hwm0", hwm0, STATS ? 16 : 0);
      chk("full_ovf_end", ovf, STATS ? 2'b01 : 2'b00);

      // response path passthrough
      up_rx.c0.rspValid  = 1'b1;
      up_rx.c0.hdr.mdata = 16'hBEEF;
      up_rx.c0.data      = {8{64'h0123_4567_89AB_CDEF}};
      up_rx.c1.rspValid  = 1'b1;
      up_rx.c1.hdr.mdata = 16'h5A5A;
      tick();
      up_rx.c0.rspValid = 1'b0;
      up_rx.c1.rspValid = 1'b0;
      chk("rx_c0_valid", afu_rx.c0.rspValid, 1);
      chk("rx_c0_mdata", afu_rx.c0.hdr.mdata, 16'hBEEF);
      chk("rx_c0_data", afu_rx.c0.data[63:0], 64'h0123_4567_89AB_CDEF);
      chk("rx_c1_mdata", afu_rx.c1.hdr.mdata, 16'h5A5A);
      tick();
      chk("rx_c0_valid_off", afu_rx.c0.rspValid, 0);
      chk("rx_c1_valid_off", afu_rx.c1.rspValid, 0);

      // MMIO passthrough while c0/c1 are blocked
      up_rx.c0TxAlmFull     = 1'b1;
      up_rx.c1TxAlmFull     = 1'b1;
      afu_tx.c0.valid       = 1'b1;
      afu_tx.c0.hdr.mdata   = 16'h0300;
      afu_tx.c1.valid       = 1'b1;
      afu_tx.c1.hdr.mdata   = 16'h0400;
      afu_tx.c2.mmioRdValid = 1'b1;
      afu_tx.c2.hdr.tid     = 9'h05A;
      afu_tx.c2.data        = 64'hCAFE_F00D_DEAD_BEEF;
      tick();
      afu_tx.c1.valid       = 1'b0;
      afu_tx.c2.mmioRdValid = 1'b0;
      chk("mmio_valid", up_tx.c2.mmioRdValid, 1);
      chk("mmio_tid", up_tx.c2.hdr.tid, 9'h05A);
      chk("mmio_data", up_tx.c2.data, 64'hCAFE_F00D_DEAD_BEEF);
      chk("mmio_c0_blocked", up_tx.c0.valid, 0);
      chk("mmio_c1_blocked", up_tx.c1.valid, 0);

      // reset mid-operation with 5 c0 entries queued
      for (int i = 1; i < 5; i++) begin
         afu_tx.c0.hdr.mdata = 16'h0300 + 16'(i);
         if (i == 4) afu_tx.c2.mmioRdValid = 1'b1;
         tick();
         chk("mmio_valid_off", up_tx.c2.mmioRdValid, (i == 4) ? 1 : 0);
      end
      afu_tx.c0.valid       = 1'b0;
      afu_tx.c2.mmioRdValid = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk("async_c2_cleared", up_tx.c2.mmioRdValid, 0);
      chk("async_c0_invalid", up_tx.c0.valid, 0);
      chk("async_c0_almfull", afu_rx.c0TxAlmFull, 1);
      chk("async_c1_almfull", afu_rx.c1TxAlmFull, 1);
      chk("async_hwm0", hwm0, 0);
      chk("async_ovf", ovf, 0);
      #2 rst = 1'b0;
      up_rx.c0TxAlmFull = 1'b0;
      up_rx.c1TxAlmFull = 1'b0;
      tick();
      chk("post_rst_almfull0", afu_rx.c0TxAlmFull, 0);
      chk("post_rst_almfull1", afu_rx.c1TxAlmFull, 0);
      for (int i = 0; i < 20; i++) begin
         if (up_tx.c0.valid || up_tx.c1.valid) stale++;
         tick();
      end
      chk("no_stale_entries", stale, 0);
      chk("post_rst_hwm0", hwm0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
